// File: rtl/packet_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : packet_output_arbiter
// Purpose  : Wormhole round-robin arbiter sharing one downstream flit buffer
//            among N_IN upstream buffers. Grants lock at a header and release
//            after the tail. Credit counter tracks downstream free slots.
// Options  : define ARB_LOCK_TIMEOUT_EN to release a lock that stalls for
//            TIMEOUT consecutive clocks.
// Revision : 1.0 - initial release
// ============================================================================
module packet_output_arbiter #(
  parameter int N_IN    = 4,
  parameter int WIDTH   = 10,
  parameter int ADDR_W  = 3,
  parameter int CREDITS = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_flit,
  output logic [N_IN-1:0]       pop,
  output logic [WIDTH-1:0]      out_flit,
  output logic                  out_push,
  input  logic                  credit_ret,
  output logic [N_IN-1:0]       grant,
  output logic [ADDR_W-1:0]     credit_cnt,
  output logic                  proto_err
);

  localparam int                IDX_W      = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_IN - 1);
  localparam logic [IDX_W:0]    IDX_COUNT  = (IDX_W + 1)'(N_IN);
  localparam logic [ADDR_W-1:0] CREDIT_MAX = ADDR_W'(CREDITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [IDX_W-1:0]  r_gidx, w_gidx_nx;
  logic [IDX_W-1:0]  r_rr, w_rr_nx;
  logic              r_sent, w_sent_nx;   // first flit of the packet already sent
  logic              r_tail, w_tail_nx;   // last flit sent closed the packet
  logic [N_IN-1:0]   r_grant, w_grant_nx;
  logic [N_IN-1:0]   r_pop, w_pop_nx;
  logic [WIDTH-1:0]  r_out_flit, w_flit_nx;
  logic              r_out_push, w_push_nx;
  logic              r_err, w_err_nx;
  logic [ADDR_W-1:0] r_credit, w_credit_nx;
  logic              w_ret_ovf;
  logic              w_release;

  logic [N_IN-1:0]   w_elig;
  logic [N_IN-1:0]   w_rot;
  logic [IDX_W-1:0]  w_off;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W-1:0]  w_pick;
  logic              w_gvalid;
  logic [WIDTH-1:0]  w_gflit;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int             TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] STALL_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] r_stall, w_stall_nx;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Per-input eligibility (valid header at the head) and the owner's head flit.
  always_comb begin
    w_elig   = '0;
    w_gvalid = 1'b0;
    w_gflit  = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_elig[i] = in_valid[i] & in_flit[i*WIDTH + WIDTH - 2];
      if (r_gidx == IDX_W'(i)) begin
        w_gvalid = in_valid[i];
        w_gflit  = in_flit[i*WIDTH +: WIDTH];
      end
    end
  end

  // Round-robin pick: rotate so r_rr sits at bit 0, take the lowest set bit.
  always_comb begin
    w_rot = N_IN'({w_elig, w_elig} >> r_rr);
    w_off = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    if (w_sum >= IDX_COUNT) w_sum = w_sum - IDX_COUNT;
    w_pick = w_sum[IDX_W-1:0];
  end

  // Credit update: a visible push consumes a slot, credit_ret frees one.
  always_comb begin
    w_ret_ovf   = credit_ret & ~r_out_push & (r_credit == CREDIT_MAX);
    w_credit_nx = r_credit;
    if (r_out_push & ~credit_ret)
      w_credit_nx = r_credit - ADDR_W'(1);
    else if (credit_ret & ~r_out_push & ~w_ret_ovf)
      w_credit_nx = r_credit + ADDR_W'(1);
  end

  // Next-state and registered-output decode for the packet lock FSM.
  always_comb begin
    w_state_nx = r_state;
    w_gidx_nx  = r_gidx;
    w_rr_nx    = r_rr;
    w_sent_nx  = r_sent;
    w_tail_nx  = r_tail;
    w_grant_nx = r_grant;
    w_pop_nx   = '0;
    w_push_nx  = 1'b0;
    w_flit_nx  = r_out_flit;
    w_err_nx   = w_ret_ovf;
    w_release  = 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
    w_stall_nx = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|w_elig) begin
          w_gidx_nx  = w_pick;
          w_grant_nx = N_IN'(1) << w_pick;
          w_sent_nx  = 1'b0;
          w_state_nx = S_XFER;
        end
      end
      S_XFER: begin
        if (w_gvalid && w_gflit[WIDTH-2] && r_sent) begin
          // A new header inside an open packet: abort, leave it queued.
          w_err_nx  = 1'b1;
          w_release = 1'b1;
        end else if (w_gvalid && (r_credit != '0)) begin
          w_pop_nx   = r_grant;
          w_push_nx  = 1'b1;
          w_flit_nx  = w_gflit;
          w_sent_nx  = 1'b1;
          w_tail_nx  = w_gflit[WIDTH-1];
          w_state_nx = S_GAP;
        end else begin
`ifdef ARB_LOCK_TIMEOUT_EN
          if (r_stall == STALL_LAST) begin
            w_err_nx  = 1'b1;
            w_release = 1'b1;
          end else begin
            w_stall_nx = r_stall + TO_W'(1);
          end
`endif
        end
      end
      S_GAP: begin
        if (r_tail) w_release = 1'b1;
        else        w_state_nx = S_XFER;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_release) begin
      w_state_nx = S_IDLE;
      w_grant_nx = '0;
      w_rr_nx    = (r_gidx == IDX_LAST) ? '0 : r_gidx + IDX_W'(1);
    end
  end

  // State and output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gidx     <= '0;
      r_rr       <= '0;
      r_sent     <= 1'b0;
      r_tail     <= 1'b0;
      r_grant    <= '0;
      r_pop      <= '0;
      r_out_flit <= '0;
      r_out_push <= 1'b0;
      r_err      <= 1'b0;
      r_credit   <= CREDIT_MAX;
`ifdef ARB_LOCK_TIMEOUT_EN
      r_stall    <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_gidx     <= w_gidx_nx;
      r_rr       <= w_rr_nx;
      r_sent     <= w_sent_nx;
      r_tail     <= w_tail_nx;
      r_grant    <= w_grant_nx;
      r_pop      <= w_pop_nx;
      r_out_flit <= w_flit_nx;
      r_out_push <= w_push_nx;
      r_err      <= w_err_nx;
      r_credit   <= w_credit_nx;
`ifdef ARB_LOCK_TIMEOUT_EN
      r_stall    <= w_stall_nx;
`endif
    end
  end

  assign pop        = r_pop;
  assign out_flit   = r_out_flit;
  assign out_push   = r_out_push;
  assign grant      = r_grant;
  assign credit_cnt = r_credit;
  assign proto_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_packet_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_output_arbiter
// Purpose  : Self-checking bench: table of directed vectors, hand-written
//            corner sequences and randomized traffic against a packet-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_output_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int CR = 5;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_flit = '0;
  logic [N-1:0]   pop;
  logic [W-1:0]   out_flit;
  logic           out_push;
  logic           credit_ret = 1'b0;
  logic [N-1:0]   grant;
  logic [2:0]     credit_cnt;
  logic           proto_err;

  packet_output_arbiter #(
    .N_IN(N), .WIDTH(W), .ADDR_W(3), .CREDITS(CR), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
    .pop(pop), .out_flit(out_flit), .out_push(out_push),
    .credit_ret(credit_ret), .grant(grant), .credit_cnt(credit_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- upstream buffers and downstream occupancy -------------
  logic [W-1:0] mem [N][DEPTH];
  int           hd [N];
  int           cnt [N];
  logic [N-1:0] avail = '1;
  bit           ret_mode = 0;
  int           occ = 0;
  logic [W-1:0] push_log [$];
  int           n_push = 0;
  int           n_errs_seen = 0;

  task automatic load(input int i, input logic [W-1:0] f);
    mem[i][(hd[i] + cnt[i]) % DEPTH] = f;
    cnt[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]      = (cnt[i] > 0) && avail[i];
      in_flit[i*W +: W] = (cnt[i] > 0) ? mem[i][hd[i]] : '0;
    end
  endtask

  // ---------------- reference model ----------------------------------------
  // Owner is an index (-1 when idle); a packet alternates send / gap phases.
  int           m_owner, m_rr, m_credit;
  bit           m_gap, m_sent, m_tail;
  logic [N-1:0] m_grant, m_pop;
  logic         m_push, m_err;
  logic [W-1:0] m_flit;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_credit = CR;
    m_gap = 0; m_sent = 0; m_tail = 0;
    m_grant = '0; m_pop = '0; m_push = 0; m_err = 0; m_flit = '0;
  endtask

  task automatic model_step();
    int           cred;
    bit           found, rel;
    logic [W-1:0] f;
    logic [N-1:0] pop_n;
    logic         push_n, err_n;
    pop_n = '0; push_n = 0; err_n = 0; rel = 0; found = 0;
    cred = m_credit - int'(m_push) + int'(credit_ret);
    if (cred > CR) begin
      cred  = CR;
      err_n = 1;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (!found && in_valid[i] && in_flit[i*W + W - 2]) begin
          m_owner = i;
          found   = 1;
        end
      end
      m_sent = 0; m_gap = 0;
    end else if (m_gap) begin
      m_gap = 0;
      if (m_tail) rel = 1;
    end else begin
      f = in_flit[m_owner*W +: W];
      if (in_valid[m_owner] && f[W-2] && m_sent) begin
        err_n = 1;
        rel   = 1;
      end else if (in_valid[m_owner] && m_credit > 0) begin
        pop_n[m_owner] = 1'b1;
        push_n = 1;
        m_flit = f;
        m_sent = 1;
        m_tail = f[W-1];
        m_gap  = 1;
      end
    end
    if (rel) begin
      m_rr    = (m_owner + 1) % N;
      m_owner = -1;
    end
    m_grant  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    m_pop    = pop_n;
    m_push   = push_n;
    m_err    = err_n;
    m_credit = cred;
  endtask

  // One clock: drive, predict, clock, compare, then let the environment react.
  task automatic run_cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check("grant", grant, m_grant);
    check("pop", pop, m_pop);
    check("out_push", out_push, m_push);
    check("out_flit", out_flit, m_flit);
    check("credit_cnt", credit_cnt, m_credit);
    check("proto_err", proto_err, m_err);
    for (int i = 0; i < N; i++) begin
      if (pop[i] && cnt[i] > 0) begin
        hd[i] = (hd[i] + 1) % DEPTH;
        cnt[i]--;
      end
    end
    if (out_push) begin
      push_log.push_back(out_flit);
      n_push++;
      occ++;
    end
    if (proto_err) n_errs_seen++;
    if (ret_mode) begin
      credit_ret = (occ > 0) && ($urandom_range(0, 2) == 0);
      if (credit_ret) occ--;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_pop"}, pop, 0);
    check({tag, "_push"}, out_push, 0);
    check({tag, "_flit"}, out_flit, 0);
    check({tag, "_credit"}, credit_cnt, CR);
    check({tag, "_err"}, proto_err, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    credit_ret = 0;
    ret_mode = 0;
    occ = 0;
    avail = '1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      cnt[i] = 0;
    end
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    n_push = 0;
    n_errs_seen = 0;
    push_log.delete();
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic [N-1:0] vld;
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    logic [N-1:0] g;
    logic         push;
    logic [N-1:0] p;
    logic [W-1:0] of;
    logic [2:0]   cr;
  } vec_t;

  vec_t tbl [9];

  task automatic gen_packet(input int i);
    int len;
    len = $urandom_range(1, 5);
    if (len == 1) begin
      load(i, {2'b11, 8'($urandom)});
    end else begin
      load(i, {2'b01, 8'($urandom)});
      for (int b = 0; b < len - 2; b++) load(i, {2'b00, 8'($urandom)});
      // Occasionally drop the tail so the next header arrives mid-packet.
      if ($urandom_range(0, 9) != 0) load(i, {2'b10, 8'($urandom)});
    end
  endtask

  initial begin
    // Single packet on input 1 (header k=0): pushes at edges 2, 4, 6. The
    // counter reflects a push one edge after out_push rises. The final row
    // shows rr_ptr=2: with inputs 1 and 2 both requesting, 2 wins.
    tbl[0] = '{4'b0010, 10'h105, 10'h000, 4'b0010, 1'b0, 4'b0000, 10'h000, 3'd5};
    tbl[1] = '{4'b0010, 10'h105, 10'h000, 4'b0010, 1'b1, 4'b0010, 10'h105, 3'd5};
    tbl[2] = '{4'b0010, 10'h0AA, 10'h000, 4'b0010, 1'b0, 4'b0000, 10'h105, 3'd4};
    tbl[3] = '{4'b0010, 10'h0AA, 10'h000, 4'b0010, 1'b1, 4'b0010, 10'h0AA, 3'd4};
    tbl[4] = '{4'b0010, 10'h2BB, 10'h000, 4'b0010, 1'b0, 4'b0000, 10'h0AA, 3'd3};
    tbl[5] = '{4'b0010, 10'h2BB, 10'h000, 4'b0010, 1'b1, 4'b0010, 10'h2BB, 3'd3};
    tbl[6] = '{4'b0000, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0000, 10'h2BB, 3'd2};
    tbl[7] = '{4'b0000, 10'h000, 10'h000, 4'b0000, 1'b0, 4'b0000, 10'h2BB, 3'd2};
    tbl[8] = '{4'b0110, 10'h311, 10'h322, 4'b0100, 1'b0, 4'b0000, 10'h2BB, 3'd2};

    do_reset();
    check_reset_outputs("reset");

    for (int r = 0; r < 9; r++) begin
      in_valid = tbl[r].vld;
      in_flit  = '0;
      in_flit[1*W +: W] = tbl[r].f1;
      in_flit[2*W +: W] = tbl[r].f2;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_grant", r), grant, tbl[r].g);
      check($sformatf("tbl%0d_push", r), out_push, tbl[r].push);
      check($sformatf("tbl%0d_pop", r), pop, tbl[r].p);
      check($sformatf("tbl%0d_flit", r), out_flit, tbl[r].of);
      check($sformatf("tbl%0d_credit", r), credit_cnt, tbl[r].cr);
      check($sformatf("tbl%0d_err", r), proto_err, 1'b0);
    end

    // Round-robin: 0 then 2; afterwards rr_ptr=3, so the search 3,0,1
    // reaches input 0 before input 1.
    do_reset();
    load(0, 10'h301);
    load(2, 10'h302);
    repeat (12) run_cycle();
    load(0, 10'h303);
    load(1, 10'h304);
    repeat (12) run_cycle();
    check("rr_count", n_push, 4);
    if (push_log.size() == 4) begin
      check("rr_first", push_log[0], 10'h301);
      check("rr_second", push_log[1], 10'h302);
      check("rr_third", push_log[2], 10'h303);
      check("rr_fourth", push_log[3], 10'h304);
    end

    // Credit stall: 7-flit packet, no returns -> 5 pushes then a held lock.
    do_reset();
    load(3, 10'h1A0);
    for (int b = 1; b <= 5; b++) load(3, 10'(b));
    load(3, 10'h2A6);
    repeat (40) run_cycle();
    check("stall_pushes", n_push, 5);
    check("stall_grant", grant, 4'b1000);
    credit_ret = 1;
    run_cycle();
    credit_ret = 0;
    repeat (20) run_cycle();
    check("stall_one_more", n_push, 6);
    check("stall_grant_held", grant, 4'b1000);

    // Credit return in the push clock, then a return at full credit.
    do_reset();
    load(0, 10'h301);
    for (int c = 0; c < 10 && !out_push; c++) run_cycle();
    check("simul_push_seen", out_push, 1'b1);
    credit_ret = 1;
    run_cycle();
    credit_ret = 0;
    check("simul_credit", credit_cnt, CR);
    repeat (3) run_cycle();
    credit_ret = 1;
    run_cycle();
    credit_ret = 0;
    check("sat_err", proto_err, 1'b1);
    check("sat_credit", credit_cnt, CR);
    run_cycle();
    check("sat_err_pulse", proto_err, 1'b0);

    // Malformed: header then header; second header becomes a new packet.
    do_reset();
    load(0, 10'h110);
    load(0, 10'h120);
    repeat (20) run_cycle();
    check("mal_errs", n_errs_seen, 1);
    check("mal_pushes", n_push, 2);
    if (push_log.size() == 2) begin
      check("mal_first", push_log[0], 10'h110);
      check("mal_second", push_log[1], 10'h120);
    end
    check("mal_regrant", grant, 4'b0001);

    // Reset after the body flit of a three-flit packet.
    do_reset();
    load(1, 10'h105);
    load(1, 10'h0AA);
    load(1, 10'h2BB);
    for (int c = 0; c < 20 && n_push < 2; c++) run_cycle();
    check("mid_reached", n_push, 2);
    #3;
    rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) run_cycle();
    check("midrst_no_push", n_push, 2);

    // Randomized traffic with random stalls and credit returns.
    do_reset();
    ret_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] < 8 && $urandom_range(0, 7) == 0) gen_packet(i);
        avail[i] = ($urandom_range(0, 7) != 0);
      end
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
